cosim_msg_deserializer: RTL and testbench

COSIM_MSG_DESERIALIZER -- requirements
Module: cosim_msg_deserializer

---
 rtl/cosim_msg_deserializer.sv | 129 ++++++++++++
 tb/tb_cosim_msg_deserializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_msg_deserializer.sv
// Byte-stream to message deserializer with HOLD backpressure.
// Optional ByteInLast framing check: COSIM_DESER_FRAME_CHECK_EN.
module cosim_msg_deserializer #(
  parameter int MSG_SIZE_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ByteInValid,
  output logic                     ByteInReady,
  input  logic [7:0]               ByteIn,
  input  logic                     ByteInLast,
  output logic                     DataOutValid,
  input  logic                     DataOutReady,
  output logic [MSG_SIZE_BITS-1:0] DataOut,
  output logic                     FrameError
);

  localparam int MSG_SIZE_BYTES = (MSG_SIZE_BITS + 7) / 8;
  localparam int MSG_SIZE_BITS_DIFF = MSG_SIZE_BITS % 8;
  localparam int TOP_BITS =
    (MSG_SIZE_BITS_DIFF == 0) ? 8 : MSG_SIZE_BITS_DIFF;
  localparam int IDXW =
    (MSG_SIZE_BYTES > 1) ? $clog2(MSG_SIZE_BYTES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(MSG_SIZE_BYTES - 1);

  if (MSG_SIZE_BITS < 1) begin : g_bad_size
    $error("MSG_SIZE_BITS must be at least 1");
  end

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [MSG_SIZE_BITS-1:0] buf_q, buf_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
  logic                     acc;
  logic                     at_last;

  // Ready is a pure decode of registered state.
  assign ByteInReady  = (state_q != HOLD);
  assign acc          = ByteInValid && ByteInReady;
  assign at_last      = (idx_q == IDX_LAST);
  assign DataOutValid = valid_q;
  assign DataOut      = buf_q;
  assign FrameError   = ferr_q;

  // Next-state, byte placement and framing decisions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (acc) begin
          for (int i = 0; i < MSG_SIZE_BITS; i++) begin
            if (int'(idx_q) == i / 8 &&
                (i / 8 < MSG_SIZE_BYTES - 1 || i % 8 < TOP_BITS))
              buf_d[i] = ByteIn[i % 8];
          end
`ifdef COSIM_DESER_FRAME_CHECK_EN
          if (at_last) begin
            idx_d = '0;
            if (ByteInLast) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end else begin
              state_d = DISCARD;
              ferr_d  = 1'b1;
            end
          end else if (ByteInLast) begin
            idx_d  = '0;
            ferr_d = 1'b1;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
`else
          if (at_last) begin
            idx_d   = '0;
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
`endif
        end
      end
      HOLD: begin
        if (DataOutReady) begin
          valid_d = 1'b0;
          state_d = COLLECT;
        end
      end
      DISCARD: begin
        if (acc && ByteInLast)
          state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, counter, buffer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: tb/tb_cosim_msg_deserializer.sv
// Directed bench for cosim_msg_deserializer.
// 12-bit instance for framing/backpressure, 8-bit for single-byte frames.
module tb_cosim_msg_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        vin = 1'b0;
  logic [7:0]  b = '0;
  logic        lst = 1'b0;
  logic        ordy = 1'b0;
  logic        rdy, vld, ferr;
  logic [11:0] dout;

  logic        vin8 = 1'b0;
  logic [7:0]  b8 = '0;
  logic        lst8 = 1'b0;
  logic        ordy8 = 1'b1;
  logic        rdy8, vld8, ferr8;
  logic [7:0]  dout8;

  int total = 0;
  int bad = 0;

  logic [11:0] msgs12[$];
  logic [7:0]  msgs8[$];
  int          nferr12 = 0;
  int          nferr8 = 0;

  always #5 clk = ~clk;

  cosim_msg_deserializer #(.MSG_SIZE_BITS(12)) u_dut (
    .clk(clk), .rst(rst),
    .ByteInValid(vin), .ByteInReady(rdy),
    .ByteIn(b), .ByteInLast(lst),
    .DataOutValid(vld), .DataOutReady(ordy),
    .DataOut(dout), .FrameError(ferr)
  );

  cosim_msg_deserializer #(.MSG_SIZE_BITS(8)) u_d8 (
    .clk(clk), .rst(rst),
    .ByteInValid(vin8), .ByteInReady(rdy8),
    .ByteIn(b8), .ByteInLast(lst8),
    .DataOutValid(vld8), .DataOutReady(ordy8),
    .DataOut(dout8), .FrameError(ferr8)
  );

  always @(negedge clk) begin
    if (rst) begin
      if (vld && ordy) msgs12.push_back(dout);
      if (ferr) nferr12++;
      if (vld8 && ordy8) msgs8.push_back(dout8);
      if (ferr8) nferr8++;
    end
  end

  typedef struct {
    logic        vin;
    logic [7:0]  b;
    logic        lst;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [11:0] e_dat;
    logic        e_ferr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    vin = 1'b0;
    vin8 = 1'b0;
    #1;
    chk("rst_vld", 32'(vld), 0);
    chk("rst_ferr", 32'(ferr), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_dout", 32'(dout), 0);
    msgs12.delete();
    msgs8.delete();
    nferr12 = 0;
    nferr8 = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    b = d;
    lst = l;
    vin = 1'b1;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 1, 0);
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d, input logic l);
    int n = 0;
    b8 = d;
    lst8 = l;
    vin8 = 1'b1;
    while (!rdy8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send8_timeout", 1, 0);
    @(negedge clk);
    vin8 = 1'b0;
  endtask

  task automatic chk_msgs12(input logic [11:0] e[$], input int ef);
    repeat (4) @(negedge clk);
    chk("n_msgs", msgs12.size(), e.size());
    for (int i = 0; i < e.size() && i < msgs12.size(); i++)
      chk("msg", 32'(msgs12[i]), 32'(e[i]));
    chk("n_ferr", nferr12, ef);
  endtask

  initial begin
    logic [11:0] e12[$];

    // vin, byte, last, ordy | rdy, vld, data, ferr
    vecs[0]  = '{0, 8'h00, 0, 0, 1, 0, 12'h000, 0};
    vecs[1]  = '{1, 8'hCD, 0, 0, 1, 0, 12'h000, 0};
    vecs[2]  = '{1, 8'h3B, 1, 0, 1, 0, 12'h000, 0};
    vecs[3]  = '{0, 8'h00, 0, 1, 0, 1, 12'hBCD, 0};
    vecs[4]  = '{0, 8'h00, 0, 0, 1, 0, 12'h000, 0};
    vecs[5]  = '{1, 8'hCD, 0, 0, 1, 0, 12'h000, 0};
    vecs[6]  = '{1, 8'h3B, 1, 0, 1, 0, 12'h000, 0};
    vecs[7]  = '{0, 8'h00, 0, 0, 0, 1, 12'hBCD, 0};
    vecs[8]  = '{0, 8'h00, 0, 0, 0, 1, 12'hBCD, 0};
    vecs[9]  = '{0, 8'h00, 0, 0, 0, 1, 12'hBCD, 0};
    vecs[10] = '{0, 8'h00, 0, 0, 0, 1, 12'hBCD, 0};
    vecs[11] = '{0, 8'h00, 0, 0, 0, 1, 12'hBCD, 0};
    vecs[12] = '{0, 8'h00, 0, 1, 0, 1, 12'hBCD, 0};
    vecs[13] = '{0, 8'h00, 0, 0, 1, 0, 12'h000, 0};

    repeat (2) @(negedge clk);
    chk("init_vld", 32'(vld), 0);
    chk("init_ferr", 32'(ferr), 0);
    rst = 1'b1;
    chk("init_dout", 32'(dout), 0);

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("v%0d_rdy", i), 32'(rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_vld", i), 32'(vld), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d_ferr", i), 32'(ferr), 32'(vecs[i].e_ferr));
      if (vecs[i].e_vld)
        chk($sformatf("v%0d_dat", i), 32'(dout), 32'(vecs[i].e_dat));
      vin = vecs[i].vin;
      b = vecs[i].b;
      lst = vecs[i].lst;
      ordy = vecs[i].ordy;
      @(negedge clk);
    end
    ordy = 1'b1;

    // early last, then good frame
    do_reset();
    send(8'h11, 1);
    send(8'h22, 0);
    send(8'h03, 1);
`ifdef COSIM_DESER_FRAME_CHECK_EN
    e12 = '{12'h322};
    chk_msgs12(e12, 1);
`else
    e12 = '{12'h211};
    chk_msgs12(e12, 0);
`endif

    // missing last, discard until last, good frame
    do_reset();
    send(8'h44, 0);
    send(8'h05, 0);
    send(8'h66, 0);
    send(8'h77, 1);
    send(8'h88, 0);
    send(8'h09, 1);
`ifdef COSIM_DESER_FRAME_CHECK_EN
    e12 = '{12'h988};
    chk_msgs12(e12, 1);
`else
    e12 = '{12'h544, 12'h766, 12'h988};
    chk_msgs12(e12, 0);
`endif

    // reset mid-frame
    do_reset();
    send(8'hAA, 0);
    do_reset();
    send(8'h12, 0);
    send(8'h0F, 1);
    e12 = '{12'hF12};
    chk_msgs12(e12, 0);

    // reset while holding a message
    ordy = 1'b0;
    send(8'hCD, 0);
    send(8'h3B, 1);
    chk("hold_vld", 32'(vld), 1);
    chk("hold_dat", 32'(dout), 32'h0BCD);
    do_reset();
    ordy = 1'b1;
    chk("post_hold_vld", 32'(vld), 0);
    send(8'h12, 0);
    send(8'h0F, 1);
    e12 = '{12'hF12};
    chk_msgs12(e12, 0);

    // single-byte messages
    do_reset();
`ifdef COSIM_DESER_FRAME_CHECK_EN
    send8(8'h5A, 1);
    send8(8'hA5, 1);
`else
    send8(8'h5A, 0);
    send8(8'hA5, 0);
`endif
    repeat (4) @(negedge clk);
    chk("n_msgs8", msgs8.size(), 2);
    if (msgs8.size() == 2) begin
      chk("msg8_0", 32'(msgs8[0]), 32'h5A);
      chk("msg8_1", 32'(msgs8[1]), 32'hA5);
    end
    chk("n_ferr8", nferr8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
